// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger pulse generator: CSR map, CTRL/STATUS
// bit positions and the FSM state encoding.
package trigger_pkg;

    // CSR addresses
    localparam int unsigned CSR_CTRL   = 0;
    localparam int unsigned CSR_DELAY  = 1;
    localparam int unsigned CSR_WIDTH  = 2;
    localparam int unsigned CSR_PERIOD = 3;
    localparam int unsigned CSR_COUNT  = 4;
    localparam int unsigned CSR_STATUS = 5;
    localparam int unsigned CSR_PULSES = 6;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_POL    = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } trig_state_e;

endpackage

// File: rtl/trigger_csr_bank.sv
// Register file for the trigger pulse generator: configuration registers,
// START/STOP write-1 pulses, sticky DONE flag and the registered read mux.
module trigger_csr_bank
    import trigger_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ADR_W = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [ADR_W-1:0] csr_adr,
    input  logic             csr_we,
    input  logic [CNT_W-1:0] csr_dat_w,
    output logic [CNT_W-1:0] csr_dat_r,
    input  logic             busy,
    input  logic             done_set,
    input  logic [CNT_W-1:0] pulses,
    output logic             start_pls,
    output logic             stop_pls,
    output logic             pol,
    output logic             pol_nxt,
    output logic             irq_en,
    output logic             done,
    output logic [CNT_W-1:0] delay,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] count
);

    localparam logic [ADR_W-1:0] A_CTRL   = ADR_W'(CSR_CTRL);
    localparam logic [ADR_W-1:0] A_DELAY  = ADR_W'(CSR_DELAY);
    localparam logic [ADR_W-1:0] A_WIDTH  = ADR_W'(CSR_WIDTH);
    localparam logic [ADR_W-1:0] A_PERIOD = ADR_W'(CSR_PERIOD);
    localparam logic [ADR_W-1:0] A_COUNT  = ADR_W'(CSR_COUNT);
    localparam logic [ADR_W-1:0] A_STATUS = ADR_W'(CSR_STATUS);
    localparam logic [ADR_W-1:0] A_PULSES = ADR_W'(CSR_PULSES);

    logic             pol_q,    pol_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q,   done_d;
    logic [CNT_W-1:0] delay_q,  delay_d;
    logic [CNT_W-1:0] width_q,  width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] dat_r_q,  dat_r_d;
    logic             wr_ctrl;

    // Write decode, START/STOP strobes (STOP wins), DONE sticky logic and read mux
    always_comb begin
        pol_d    = pol_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        delay_d  = delay_q;
        width_d  = width_q;
        period_d = period_q;
        count_d  = count_q;
        dat_r_d  = '0;

        wr_ctrl   = csr_we && (csr_adr == A_CTRL);
        stop_pls  = wr_ctrl && csr_dat_w[CTRL_STOP];
        start_pls = wr_ctrl && csr_dat_w[CTRL_START] && !csr_dat_w[CTRL_STOP];

        if (csr_we) begin
            case (csr_adr)
                A_CTRL: begin
                    pol_d    = csr_dat_w[CTRL_POL];
                    irq_en_d = csr_dat_w[CTRL_IRQ_EN];
                end
                A_DELAY:  delay_d  = csr_dat_w;
                A_WIDTH:  width_d  = csr_dat_w;
                A_PERIOD: period_d = csr_dat_w;
                A_COUNT:  count_d  = csr_dat_w;
                A_STATUS: if (csr_dat_w[STAT_DONE]) done_d = 1'b0;
                default: ;
            endcase
        end
        // A completing burst beats a simultaneous write-1-to-clear
        if (done_set) done_d = 1'b1;

        case (csr_adr)
            A_CTRL: begin
                dat_r_d[CTRL_POL]    = pol_q;
                dat_r_d[CTRL_IRQ_EN] = irq_en_q;
            end
            A_DELAY:  dat_r_d = delay_q;
            A_WIDTH:  dat_r_d = width_q;
            A_PERIOD: dat_r_d = period_q;
            A_COUNT:  dat_r_d = count_q;
            A_STATUS: begin
                dat_r_d[STAT_BUSY] = busy;
                dat_r_d[STAT_DONE] = done_q;
            end
            A_PULSES: dat_r_d = pulses;
            default:  dat_r_d = '0;
        endcase
    end

    // Register state with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pol_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            delay_q  <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            dat_r_q  <= '0;
        end else begin
            pol_q    <= pol_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            period_q <= period_d;
            count_q  <= count_d;
            dat_r_q  <= dat_r_d;
        end
    end

    assign csr_dat_r = dat_r_q;
    assign pol       = pol_q;
    assign pol_nxt   = pol_d;
    assign irq_en    = irq_en_q;
    assign done      = done_q;
    assign delay     = delay_q;
    assign width     = width_q;
    assign period    = period_q;
    assign count     = count_q;

endmodule

// File: rtl/trigger_pulse_gen.sv
// CSR-programmed pulse-train generator driving the trigger pad.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | waiting for START; trigger at inactive level
//  ST_DELAY | counting DELAY+1 cycles before the first rising edge
//  ST_HIGH  | trigger active for WIDTH_eff cycles
//  ST_LOW   | trigger inactive for max(PERIOD-WIDTH_eff,1) cycles
module trigger_pulse_gen
    import trigger_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ADR_W = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [ADR_W-1:0] csr_adr,
    input  logic             csr_we,
    input  logic [CNT_W-1:0] csr_dat_w,
    output logic [CNT_W-1:0] csr_dat_r,
    output logic             trigger,
    output logic             busy,
    output logic             irq
);

    logic             start_pls, stop_pls;
    logic             pol, pol_nxt, irq_en, done;
    logic             done_set;
    logic [CNT_W-1:0] reg_delay, reg_width, reg_period, reg_count;

    trig_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic             inf_q,    inf_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic [CNT_W-1:0] wid_sh_q, wid_sh_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic             trigger_q, trigger_d;

    logic [CNT_W-1:0] width_eff;
    logic [CNT_W-1:0] low_len;

    trigger_csr_bank #(
        .CNT_W (CNT_W),
        .ADR_W (ADR_W)
    ) u_csr (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .csr_adr   (csr_adr),
        .csr_we    (csr_we),
        .csr_dat_w (csr_dat_w),
        .csr_dat_r (csr_dat_r),
        .busy      (busy),
        .done_set  (done_set),
        .pulses    (pulses_q),
        .start_pls (start_pls),
        .stop_pls  (stop_pls),
        .pol       (pol),
        .pol_nxt   (pol_nxt),
        .irq_en    (irq_en),
        .done      (done),
        .delay     (reg_delay),
        .width     (reg_width),
        .period    (reg_period),
        .count     (reg_count)
    );

    // Effective pulse geometry from the shadowed WIDTH/PERIOD
    always_comb begin
        width_eff = (wid_sh_q == '0) ? CNT_W'(1) : wid_sh_q;
        low_len   = (per_sh_q > width_eff) ? (per_sh_q - width_eff) : CNT_W'(1);
    end

    // Next-state, counter and trigger-level logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        inf_d     = inf_q;
        pulses_d  = pulses_q;
        wid_sh_d  = wid_sh_q;
        per_sh_d  = per_sh_q;
        done_set  = 1'b0;

        if (stop_pls) begin
            // STOP freezes PULSES and never reports completion
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_pls) begin
                        state_d  = ST_DELAY;
                        cnt_d    = reg_delay;
                        wid_sh_d = reg_width;
                        per_sh_d = reg_period;
                        rem_d    = reg_count;
                        inf_d    = (reg_count == '0);
                        pulses_d = '0;
                    end
                end
                ST_DELAY, ST_LOW: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_HIGH;
                        cnt_d    = width_eff - CNT_W'(1);
                        pulses_d = pulses_q + CNT_W'(1);
                        if (!inf_q) rem_d = rem_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        if (inf_q || (rem_q != '0)) begin
                            state_d = ST_LOW;
                            cnt_d   = low_len - CNT_W'(1);
                        end else begin
                            state_d  = ST_IDLE;
                            done_set = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Uses the incoming POL value so a polarity write shows on the next cycle
        trigger_d = (state_d == ST_HIGH) ^ pol_nxt;
    end

    // FSM, counters and output register with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            inf_q     <= 1'b0;
            pulses_q  <= '0;
            wid_sh_q  <= '0;
            per_sh_q  <= '0;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            inf_q     <= inf_d;
            pulses_q  <= pulses_d;
            wid_sh_q  <= wid_sh_d;
            per_sh_q  <= per_sh_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger = trigger_q;
    assign busy    = (state_q != ST_IDLE);
    assign irq     = done & irq_en;

    // pol is consumed through pol_nxt; keep the registered copy referenced
    logic unused_pol;
    assign unused_pol = pol;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen: directed scenarios plus random
// bursts compared against a cycle-offset model of the pulse train.
module tb_trigger_pulse_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  csr_adr = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_dat_w = '0;
    logic [31:0] csr_dat_r;
    logic        trigger;
    logic        busy;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    trigger_pulse_gen #(.CNT_W(32), .ADR_W(3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .csr_adr   (csr_adr),
        .csr_we    (csr_we),
        .csr_dat_w (csr_dat_w),
        .csr_dat_r (csr_dat_r),
        .trigger   (trigger),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_adr   = a;
        csr_dat_w = d;
        tick();
        csr_we    = 1'b0;
        csr_dat_w = '0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] v);
        csr_we  = 1'b0;
        csr_adr = a;
        tick();
        v = csr_dat_r;
    endtask

    // Is the pulse train active n cycles after the START write edge?
    function automatic bit model_active(int n, int d, int weff, int pe, int c);
        int off;
        if (n < d + 1) return 1'b0;
        off = n - (d + 1);
        if (c != 0 && (off / pe) >= c) return 1'b0;
        return (off % pe) < weff;
    endfunction

    task automatic run_burst(input int d, input int w, input int p, input int c,
                             input bit pol, input bit ien, input bit wr_cfg, input bit mid);
        int weff, lowl, pe, t_end;
        logic [31:0] v;
        weff  = (w == 0) ? 1 : w;
        lowl  = (p > weff) ? p - weff : 1;
        pe    = weff + lowl;
        t_end = d + 1 + (c - 1) * pe + weff;
        if (wr_cfg) begin
            csr_write(3'd1, 32'(d));
            csr_write(3'd2, 32'(w));
            csr_write(3'd3, 32'(p));
            csr_write(3'd4, 32'(c));
        end
        csr_write(3'd5, 32'h2);
        csr_write(3'd0, {28'd0, ien, pol, 2'b01});
        for (int n = 0; n <= t_end + 2; n++) begin
            if (n > 0) begin
                csr_we = 1'b0; csr_adr = '0; csr_dat_w = '0;
                if (mid && n == 2) begin
                    csr_we = 1'b1; csr_adr = 3'd2; csr_dat_w = 32'd7;
                end
                if (mid && n == 4) begin
                    csr_we = 1'b1; csr_adr = 3'd0; csr_dat_w = {28'd0, ien, pol, 2'b01};
                end
                tick();
            end
            chk("trigger", 32'(trigger), 32'(model_active(n, d, weff, pe, c) ^ pol));
            chk("busy", 32'(busy), 32'(n < t_end));
            chk("irq", 32'(irq), 32'(ien && (n >= t_end)));
        end
        csr_we = 1'b0; csr_dat_w = '0;
        csr_read(3'd6, v);
        chk("pulses", v, 32'(c));
        csr_read(3'd5, v);
        chk("status_done", v, 32'h2);
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        repeat (3) tick();
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dat_r", csr_dat_r, 32'd0);
        sys_rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), v);
            chk("rst_reg", v, 32'd0);
        end

        // START|STOP together (with POL, IRQ_EN): stays idle
        csr_write(3'd0, 32'hF);
        for (int i = 0; i < 6; i++) begin
            chk("ss_busy", 32'(busy), 32'd0);
            chk("ss_trig", 32'(trigger), 32'd1);
            tick();
        end
        csr_read(3'd0, v);
        chk("ctrl_read", v, 32'hC);
        csr_write(3'd7, 32'hFFFF_FFFF);
        csr_read(3'd7, v);
        chk("addr7", v, 32'd0);
        csr_write(3'd0, 32'h0);

        // Directed burst: rises at +3/+8, done at +11
        run_burst(2, 3, 5, 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // 1-high/1-low x3 with irq, then clear
        run_burst(0, 0, 0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("irq_held", 32'(irq), 32'd1);
        csr_write(3'd5, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);

        // Free-running burst stopped during the 20th pulse
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd2);
        csr_write(3'd3, 32'd5);
        csr_write(3'd4, 32'd0);
        csr_write(3'd0, 32'h1);
        for (int n = 0; n <= 97; n++) begin
            if (n > 0) tick();
            chk("inf_trig", 32'(trigger), 32'(model_active(n, 1, 2, 5, 0)));
            chk("inf_busy", 32'(busy), 32'd1);
        end
        csr_write(3'd0, 32'h2);
        chk("stop_trig", 32'(trigger), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        tick();
        chk("stop_trig2", 32'(trigger), 32'd0);
        csr_read(3'd6, v);
        chk("stop_pulses", v, 32'd20);
        csr_read(3'd5, v);
        chk("stop_status", v, 32'd0);

        // Mid-burst WIDTH write and ignored START; next burst uses width 7
        run_burst(0, 2, 6, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        csr_read(3'd2, v);
        chk("width_reg", v, 32'd7);
        run_burst(0, 7, 6, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during HIGH truncates the pulse
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd5);
        csr_write(3'd3, 32'd8);
        csr_write(3'd4, 32'd1);
        csr_write(3'd0, 32'h1);
        tick(); tick(); tick();
        chk("pre_rst_trig", 32'(trigger), 32'd1);
        sys_rst = 1'b1;
        tick();
        chk("mid_rst_trig", 32'(trigger), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        csr_read(3'd2, v);
        chk("mid_rst_width", v, 32'd0);

        // Active-low polarity from reset release
        csr_write(3'd0, 32'h4);
        chk("pol_idle", 32'(trigger), 32'd1);
        tick();
        chk("pol_idle2", 32'(trigger), 32'd1);
        run_burst(1, 2, 4, 2, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random bursts
        for (int r = 0; r < 10; r++) begin
            run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 8)), int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
